mux16_rr_sel_ctrl: RTL and testbench

- Round-robin controller that shares a 16:1 single-bit select mux between 16 requesters and drives its 4-bit select.
- Each requester asserts a request line. The controller grants one requester at a time, drives `sel` to that requester's index, and holds it until release, request drop, or a hold timeout.
- Sits directly in front of the 16-input mux. `sel` connects to the mux select; `grant` connects back to the requesters.

---
 rtl/mux16_rr_sel_ctrl.sv | 144 ++++++++++++++
 tb/tb_mux16_rr_sel_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_sel_ctrl.sv
// mux16_rr_sel_ctrl: round-robin owner selection for a shared 16:1 select mux.
// A single owner is granted at a time. The grant ends on release, on a dropped
// request, or when the hold limit is reached. There is always one dead cycle
// between grants, and sel keeps the last owner's index while no one is granted.
module mux16_rr_sel_ctrl #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      req,
  input  logic             rel,
  output logic [3:0]       sel,
  output logic [15:0]      grant,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [15:0]      grant_q, grant_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       last_owner_q, last_owner_d;

  logic [3:0]       win_idx_s;
  logic             win_found_s;
  logic             end_s;
  logic             to_end_s;

  // Round-robin pick: scan from the farthest offset to the nearest so the first set bit after last_owner wins.
  always_comb begin
    win_idx_s   = 4'd0;
    win_found_s = |req;
    for (int k = 16; k >= 1; k--) begin
      win_idx_s = req[4'(last_owner_q + 4'(k))] ? 4'(last_owner_q + 4'(k)) : win_idx_s;
    end
  end

  // Next-state logic, including the grant-end and timeout-end decisions.
  always_comb begin
    state_d  = state_q;
    end_s    = 1'b0;
    to_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel || !req[sel_q]) begin
          end_s   = 1'b1;
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          end_s    = 1'b1;
          to_end_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and of the round-robin pointer.
  always_comb begin
    sel_d        = sel_q;
    grant_d      = grant_q;
    gnt_valid_d  = gnt_valid_q;
    timeout_d    = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          sel_d       = win_idx_s;
          grant_d     = 16'h0001 << win_idx_s;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = {CNT_W{1'b0}};
        end else begin
          grant_d     = 16'h0000;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (end_s) begin
          grant_d      = 16'h0000;
          gnt_valid_d  = 1'b0;
          last_owner_d = sel_q;
          timeout_d    = to_end_s;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d     = 16'h0000;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset leaves last_owner at 15 so requester 0 has top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 4'd0;
      grant_q      <= 16'h0000;
      gnt_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      hold_cnt_q   <= {CNT_W{1'b0}};
      last_owner_q <= 4'd15;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      gnt_valid_q  <= gnt_valid_d;
      timeout_q    <= timeout_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_mux16_rr_sel_ctrl.sv
// Testbench for mux16_rr_sel_ctrl: a cycle model pushes the expected outputs
// into a queue when each cycle's stimulus is driven. The entry is popped and
// compared one edge later. Each scenario task also checks its directed results.
module tb_mux16_rr_sel_ctrl;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             rst;
  logic [15:0]      req;
  logic             rel;
  logic [3:0]       sel;
  logic [15:0]      grant;
  logic             gnt_valid;
  logic             timeout;
  logic [CNT_W-1:0] hold_cnt;

  typedef struct {
    logic [3:0]       sel;
    logic [15:0]      grant;
    logic             gnt_valid;
    logic             timeout;
    logic [CNT_W-1:0] hold_cnt;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit m_busy;
  int m_sel;
  int m_last;
  int m_cnt;
  bit m_to;

  mux16_rr_sel_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = 15;
    m_cnt  = 0;
    m_to   = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one edge for inputs r/rl and queue the expected outputs.
  task automatic model_push(input logic [15:0] r, input logic rl);
    exp_t e;
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 16'h0000) begin
        for (int k = 1; k <= 16; k++) begin
          if (r[(m_last + k) % 16]) begin
            m_sel = (m_last + k) % 16;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      if (rl || !r[m_sel]) begin
        m_busy = 1'b0;
        m_last = m_sel;
      end else if (m_cnt == MAX_HOLD - 1) begin
        m_busy = 1'b0;
        m_last = m_sel;
        m_to   = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.sel       = 4'(m_sel);
    e.grant     = m_busy ? (16'h0001 << m_sel) : 16'h0000;
    e.gnt_valid = m_busy;
    e.timeout   = m_to;
    e.hold_cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the scoreboard after the edge.
  task automatic cycle(input logic [15:0] r, input logic rl);
    exp_t e;
    req = r;
    rel = rl;
    model_push(r, rl);
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (sel !== e.sel || grant !== e.grant || gnt_valid !== e.gnt_valid ||
          timeout !== e.timeout || hold_cnt !== e.hold_cnt) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t got sel=%0d grant=%h gv=%b to=%b cnt=%0d want sel=%0d grant=%h gv=%b to=%b cnt=%0d",
                 $time, sel, grant, gnt_valid, timeout, hold_cnt,
                 e.sel, e.grant, e.gnt_valid, e.timeout, e.hold_cnt);
      end
    end
  endtask

  task automatic test_reset();
    req = 16'h0000;
    rel = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sel !== 4'd0 || grant !== 16'h0000 || gnt_valid !== 1'b0 ||
        timeout !== 1'b0 || hold_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state got sel=%0d grant=%h gv=%b to=%b cnt=%0d want all zero",
               sel, grant, gnt_valid, timeout, hold_cnt);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_grant();
    test_reset();
    cycle(16'h0001, 1'b0);
    vectors++;
    if (grant !== 16'h0001 || sel !== 4'd0 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant got grant=%h sel=%0d gv=%b want 0001 0 1", grant, sel, gnt_valid);
    end
    cycle(16'h0001, 1'b1);
    vectors++;
    if (grant !== 16'h0000 || sel !== 4'd0 || gnt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release got grant=%h sel=%0d gv=%b want 0000 0 0", grant, sel, gnt_valid);
    end
  endtask

  task automatic test_alternate();
    logic [15:0] want;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 16'h0001 : 16'h8000;
      cycle(16'h8001, 1'b0);
      vectors++;
      if (grant !== want) begin
        miscompares++;
        $display("FAIL alternate_order[%0d] got grant=%h want %h", i, grant, want);
      end
      cycle(16'h8001, 1'b1);
      vectors++;
      if (grant !== 16'h0000) begin
        miscompares++;
        $display("FAIL alternate_gap[%0d] got grant=%h want 0000", i, grant);
      end
    end
  endtask

  task automatic test_wrap();
    int want;
    test_reset();
    cycle(16'h0020, 1'b0);
    vectors++;
    if (sel !== 4'd5 || grant !== 16'h0020) begin
      miscompares++;
      $display("FAIL wrap_start got sel=%0d grant=%h want 5 0020", sel, grant);
    end
    cycle(16'hFFFF, 1'b1);
    for (int k = 0; k < 16; k++) begin
      want = (6 + k) % 16;
      cycle(16'hFFFF, 1'b0);
      vectors++;
      if (sel !== 4'(want) || grant !== (16'h0001 << want)) begin
        miscompares++;
        $display("FAIL wrap_order[%0d] got sel=%0d grant=%h want sel=%0d", k, sel, grant, want);
      end
      cycle(16'hFFFF, 1'b1);
    end
  endtask

  task automatic test_timeout();
    test_reset();
    for (int k = 0; k < MAX_HOLD; k++) begin
      cycle(16'h0010, 1'b0);
      vectors++;
      if (grant !== 16'h0010 || hold_cnt !== CNT_W'(k) || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_hold[%0d] got grant=%h cnt=%0d to=%b want 0010 %0d 0", k, grant, hold_cnt, timeout, k);
      end
    end
    cycle(16'h0010, 1'b0);
    vectors++;
    if (grant !== 16'h0000 || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_pulse got grant=%h to=%b want 0000 1", grant, timeout);
    end
    cycle(16'h0010, 1'b0);
    vectors++;
    if (grant !== 16'h0010 || timeout !== 1'b0 || hold_cnt !== '0) begin
      miscompares++;
      $display("FAIL timeout_regrant got grant=%h to=%b cnt=%0d want 0010 0 0", grant, timeout, hold_cnt);
    end
  endtask

  task automatic test_rel_at_limit();
    test_reset();
    for (int k = 0; k < MAX_HOLD; k++) cycle(16'h0010, 1'b0);
    vectors++;
    if (hold_cnt !== CNT_W'(MAX_HOLD - 1)) begin
      miscompares++;
      $display("FAIL rel_limit_cnt got cnt=%0d want %0d", hold_cnt, MAX_HOLD - 1);
    end
    cycle(16'h0010, 1'b1);
    vectors++;
    if (grant !== 16'h0000 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL rel_beats_timeout got grant=%h to=%b want 0000 0", grant, timeout);
    end
  endtask

  task automatic test_drop_and_async_reset();
    test_reset();
    cycle(16'h0008, 1'b0);
    cycle(16'h0000, 1'b0);
    vectors++;
    if (grant !== 16'h0000 || sel !== 4'd3) begin
      miscompares++;
      $display("FAIL req_drop got grant=%h sel=%0d want 0000 3", grant, sel);
    end
    cycle(16'h0008, 1'b0);
    cycle(16'h0008, 1'b0);
    req = 16'h0000;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (grant !== 16'h0000 || sel !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got grant=%h sel=%0d gv=%b to=%b want 0000 0 0 0", grant, sel, gnt_valid, timeout);
    end
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(16'h0009, 1'b0);
    vectors++;
    if (grant !== 16'h0001 || sel !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset_priority got grant=%h sel=%0d want 0001 0", grant, sel);
    end
    cycle(16'h0009, 1'b1);
    cycle(16'h0009, 1'b0);
    vectors++;
    if (grant !== 16'h0008 || sel !== 4'd3) begin
      miscompares++;
      $display("FAIL post_reset_next got grant=%h sel=%0d want 0008 3", grant, sel);
    end
  endtask

  task automatic test_rel_in_idle_and_masked_req();
    test_reset();
    cycle(16'h0000, 1'b1);
    cycle(16'h0004, 1'b0);
    cycle(16'h0006, 1'b0);
    vectors++;
    if (grant !== 16'h0004 || hold_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL masked_req got grant=%h cnt=%0d want 0004 1", grant, hold_cnt);
    end
    cycle(16'h0006, 1'b1);
    cycle(16'h0006, 1'b0);
    vectors++;
    if (grant !== 16'h0002) begin
      miscompares++;
      $display("FAIL rr_after_masked got grant=%h want 0002", grant);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 16'h0000;
    rel = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_single_grant();
    test_alternate();
    test_wrap();
    test_timeout();
    test_rel_at_limit();
    test_drop_and_async_reset();
    test_rel_in_idle_and_masked_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
